// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: parametrised elastic WIDTH x DEPTH valid/ready register chain.
// Each stage holds one payload word and a valid bit. Bubbles collapse while the
// tail is stalled. The chain supports back-pressure and a synchronous flush.
//
// Parameters:
//   WIDTH  payload width in bits (>=1)
//   DEPTH  number of register stages (>=1; 0 is rejected at elaboration)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset (clears valid bits and data)
//   flush      synchronous clear of all stage valid bits (data is kept)
//   in_valid   upstream data valid
//   in_ready   chain can accept in_data this cycle
//   in_data    upstream payload
//   out_valid  last stage holds valid data
//   out_ready  downstream accepts out_data this cycle
//   out_data   last-stage payload
//   occupancy  (only with PIPE_REG_CHAIN_OCC_EN) registered count of valid stages
//
// Optional feature macro: PIPE_REG_CHAIN_OCC_EN adds the occupancy output.
module pipe_reg_chain #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data
`ifdef PIPE_REG_CHAIN_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  if (DEPTH < 1 || WIDTH < 1) begin : g_bad_param
    $error("pipe_reg_chain: WIDTH and DEPTH must both be >= 1");
  end

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] v_next;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] rdy;
  logic             accept;

  // rdy[i] = !v[i] | rdy[i+1] with rdy[DEPTH] = out_ready, unrolled: a stage
  // can move when downstream accepts or any stage from i to the tail is empty.
  for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
    assign rdy[g] = out_ready | ~(&v[DEPTH-1:g]);
  end

  assign in_ready  = rdy[0] & ~flush & reset;
  assign accept    = in_valid & in_ready;
  assign out_valid = v[DEPTH-1] & ~flush & reset;
  assign out_data  = data[DEPTH-1];

  // Next-state valid bits and per-stage data load enables. Data only loads
  // when the incoming valid is set, so idle stages keep their contents.
  always_comb begin
    v_next = v;
    load   = '0;
    if (rdy[0]) begin
      v_next[0] = accept;
      load[0]   = accept;
    end
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (rdy[i]) begin
        v_next[i] = v[i-1];
        load[i]   = v[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      v <= v_next;
      if (load[0]) begin
        data[0] <= in_data;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        if (load[i]) begin
          data[i] <= data[i-1];
        end
      end
    end
  end

`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_next;

  always_comb begin
    occ_next = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ_next = occ_next + OCC_W'(v_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_next;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed self-checking bench for pipe_reg_chain
// (WIDTH=16, DEPTH=3). Inputs change 1 time unit after the rising edge;
// outputs are sampled on the falling edge.
module tb_pipe_reg_chain;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 3;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_REG_CHAIN_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pipe_reg_chain #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef PIPE_REG_CHAIN_OCC_EN
    ,
    .occupancy(occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs at the falling edge, then advance
  // to just after the next rising edge. out_data is checked only when valid.
  task automatic step(input string tag, input logic rst, input logic fl,
                      input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                      input logic exp_ir, input logic exp_ov,
                      input logic [WIDTH-1:0] exp_od);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ir));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
    if (exp_ov) check({tag, ".out_data"}, 32'(out_data), 32'(exp_od));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held low for 2 cycles.
    step("rst0", 0, 0, 0, 16'h0, 1, 0, 0, 16'h0);
    step("rst1", 0, 0, 0, 16'h0, 1, 0, 0, 16'h0);

    // Streaming, out_ready=1: 3-edge latency, one beat per cycle.
    reset = 1'b1;
    @(negedge clk);
    check("post_rst.out_data", 32'(out_data), 32'h0);
    @(posedge clk); // no input was valid, so this edge changes nothing
    #1;
    step("s0", 1, 0, 1, 16'h0001, 1, 1, 0, 16'h0);
    step("s1", 1, 0, 1, 16'h0002, 1, 1, 0, 16'h0);
    step("s2", 1, 0, 1, 16'h0003, 1, 1, 0, 16'h0);
    step("s3", 1, 0, 1, 16'h0004, 1, 1, 1, 16'h0001);
    step("s4", 1, 0, 1, 16'h0005, 1, 1, 1, 16'h0002);
    step("s5", 1, 0, 0, 16'h0000, 1, 1, 1, 16'h0003);
    step("s6", 1, 0, 0, 16'h0000, 1, 1, 1, 16'h0004);
    step("s7", 1, 0, 0, 16'h0000, 1, 1, 1, 16'h0005);
    step("s8", 1, 0, 0, 16'h0000, 1, 1, 0, 16'h0);

    // Back-pressure: fill with out_ready=0, then drain in order.
    step("bp0",  1, 0, 1, 16'h00A0, 0, 1, 0, 16'h0);
    step("bp1",  1, 0, 1, 16'h00A1, 0, 1, 0, 16'h0);
    step("bp2",  1, 0, 1, 16'h00A2, 0, 1, 0, 16'h0);
    step("bp3",  1, 0, 1, 16'h00A3, 0, 0, 1, 16'h00A0);
    step("bp4",  1, 0, 1, 16'h00A3, 0, 0, 1, 16'h00A0);
    step("bp5",  1, 0, 1, 16'h00A3, 1, 1, 1, 16'h00A0);
    step("bp6",  1, 0, 1, 16'h00A4, 1, 1, 1, 16'h00A1);
    step("bp7",  1, 0, 0, 16'h0000, 1, 1, 1, 16'h00A2);
    step("bp8",  1, 0, 0, 16'h0000, 1, 1, 1, 16'h00A3);
    step("bp9",  1, 0, 0, 16'h0000, 1, 1, 1, 16'h00A4);
    step("bp10", 1, 0, 0, 16'h0000, 1, 1, 0, 16'h0);

    // Full chain: emit and accept on the same edge.
    step("fu0", 1, 0, 1, 16'h00B0, 0, 1, 0, 16'h0);
    step("fu1", 1, 0, 1, 16'h00B1, 0, 1, 0, 16'h0);
    step("fu2", 1, 0, 1, 16'h00B2, 0, 1, 0, 16'h0);
`ifdef PIPE_REG_CHAIN_OCC_EN
    check("fu.occ_before", 32'(occupancy), 32'd3);
`endif
    step("fu3", 1, 0, 1, 16'h00B3, 1, 1, 1, 16'h00B0);
`ifdef PIPE_REG_CHAIN_OCC_EN
    check("fu.occ_after", 32'(occupancy), 32'd3);
`endif
    step("fu4", 1, 0, 0, 16'h0000, 0, 0, 1, 16'h00B1);
    step("fu5", 1, 0, 0, 16'h0000, 1, 1, 1, 16'h00B1);
    step("fu6", 1, 0, 0, 16'h0000, 1, 1, 1, 16'h00B2);
    step("fu7", 1, 0, 0, 16'h0000, 1, 1, 1, 16'h00B3);
    step("fu8", 1, 0, 0, 16'h0000, 1, 1, 0, 16'h0);

    // Bubbles compress while the tail stalls; output stays stable.
    step("bu0", 1, 0, 1, 16'h00C0, 0, 1, 0, 16'h0);
    step("bu1", 1, 0, 0, 16'h0000, 1, 1, 0, 16'h0);
    step("bu2", 1, 0, 1, 16'h00C1, 0, 1, 0, 16'h0);
    step("bu3", 1, 0, 0, 16'h0000, 0, 1, 1, 16'h00C0);
    step("bu4", 1, 0, 0, 16'h0000, 0, 1, 1, 16'h00C0);
    step("bu5", 1, 0, 0, 16'h0000, 1, 1, 1, 16'h00C0);
    step("bu6", 1, 0, 0, 16'h0000, 0, 1, 1, 16'h00C1);
    step("bu7", 1, 0, 0, 16'h0000, 1, 1, 1, 16'h00C1);
    step("bu8", 1, 0, 0, 16'h0000, 1, 1, 0, 16'h0);

    // Flush with two beats held; the beat offered during flush is dropped.
    step("fl0", 1, 0, 1, 16'h0011, 0, 1, 0, 16'h0);
    step("fl1", 1, 0, 1, 16'h0012, 0, 1, 0, 16'h0);
    step("fl2", 1, 1, 1, 16'h0013, 1, 0, 0, 16'h0);
`ifdef PIPE_REG_CHAIN_OCC_EN
    check("fl.occ", 32'(occupancy), 32'd0);
`endif
    step("fl3", 1, 0, 1, 16'h00D0, 1, 1, 0, 16'h0);
    step("fl4", 1, 0, 0, 16'h0000, 1, 1, 0, 16'h0);
    step("fl5", 1, 0, 0, 16'h0000, 1, 1, 0, 16'h0);
    step("fl6", 1, 0, 0, 16'h0000, 1, 1, 1, 16'h00D0);
    step("fl7", 1, 0, 0, 16'h0000, 1, 1, 0, 16'h0);

    // Mid-stream reset with 3 beats in flight.
    step("mr0", 1, 0, 1, 16'h0021, 0, 1, 0, 16'h0);
    step("mr1", 1, 0, 1, 16'h0022, 0, 1, 0, 16'h0);
    step("mr2", 1, 0, 1, 16'h0023, 0, 1, 0, 16'h0);
    step("mr3", 0, 0, 0, 16'h0000, 1, 0, 0, 16'h0);
    reset = 1'b1;
    @(negedge clk);
    check("mr.out_data", 32'(out_data), 32'h0);
`ifdef PIPE_REG_CHAIN_OCC_EN
    check("mr.occ", 32'(occupancy), 32'd0);
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      step("mr_idle", 1, 0, 0, 16'h0000, 1, 1, 0, 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
Parametrised elastic pipeline register chain that generalises the fixed-width D flip-flop cells into a WIDTH x DEPTH valid/ready pipeline. Each stage carries a valid bit, and bubbles collapse. It supports back-pressure and a synchronous flush. It sits between the PE array, accumulator and output-buffer stages of the NPU datapath and replaces hand-chained fixed-width flops used for timing alignment.

Parameters:
WIDTH, 8, payload width in bits (>=1)
DEPTH, 2, number of register stages (>=1); DEPTH=0 is illegal and must fail elaboration

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous active-low reset
flush  input  1  synchronous clear of all stage valid bits
in_valid  input  1  upstream data valid
in_ready  output  1  chain can accept in_data this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  last stage holds valid data
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  last-stage payload

Behaviour:
- One clock (clk); reset is synchronous and active-low (reset=0 clears on the next rising edge of clk).
- Storage: per stage i (0..DEPTH-1), data[i] (WIDTH bits) and v[i] (1 bit).
- Reset: all v[i]=0 and all data[i]=0. While reset=0, in_ready=0 and out_valid=0. After release, out_valid=0, out_data=0 and in_ready=1.
- Stage readiness:
  - rdy[DEPTH] = out_ready
  - rdy[i] = !v[i] | rdy[i+1], combinational
  - in_ready = rdy[0] & !flush & reset
- Transfers:
  - Stage i loads data[i-1] (stage 0 loads in_data) when rdy[i]=1.
  - v[i] <= v[i-1] (v[0] <= in_valid & in_ready) when rdy[i]=1; otherwise stage i holds.
  - data[i] may update only when the incoming valid is 1 (clock-gate friendly); it holds otherwise.
- Output: out_valid = v[DEPTH-1] & !flush; out_data = data[DEPTH-1].
- Latency: a beat accepted at edge N with no stall appears with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH edges after the cycle in_valid&in_ready is sampled. Throughput is 1 beat/cycle with out_ready held at 1.
- Back-pressure:
  - out_ready=0 with the chain full: all stages hold and in_ready=0.
  - Bubbles between stages compress while the tail stalls.
  - Order is always preserved; no beat is dropped or duplicated.
- Simultaneous events:
  - The last stage emits while stage 0 accepts in the same cycle: both are legal, and occupancy is unchanged.
  - Full chain with out_ready=1: in_ready=1 in the same cycle (combinational pass-through of ready).
- Flush:
  - At the edge where flush=1, all v[i] <= 0; data registers are not cleared.
  - During the flush cycle no input is accepted and no output transfer occurs.
  - Flush with reset=0: reset wins, and data is also cleared.
- Reset mid-operation clears all in-flight beats; nothing stored before reset emerges afterwards.
- AXI-style rules:
  - out_data and out_valid are stable while out_valid=1 and out_ready=0, unless flush=1.
  - in_valid may not depend on in_ready.

Optional Feature:
PIPE_REG_CHAIN_OCC_EN:
- Defined: adds output port occupancy (width $clog2(DEPTH+1)) equal to the count of set v[i], registered. It is 0 after reset and after flush, and it updates on the same edge as v.
- Undefined: port absent; no counter logic.

Test Plan:
- WIDTH=16, DEPTH=3, reset=0 for 2 cycles then 1; drive in_valid=1 with data 0x0001..0x0005, out_ready=1 -> in_ready=1 throughout; out_valid first high 3 edges after first accept; out_data 0x0001..0x0005 in consecutive cycles.
- Same config, out_ready=0 while sending 0xA0..0xA4 -> in_ready drops to 0 after 3 accepts; raise out_ready -> 0xA0,0xA1,0xA2,0xA3,0xA4 emerge in order, with no loss and no duplicates.
- Chain full (0xB0..0xB2), out_ready=1 and in_valid=1 with 0xB3 in the same cycle -> 0xB0 emitted and 0xB3 accepted that edge; occupancy stays 3 (OCC_EN).
- Alternate in_valid 1/0 with data 0xC0,0xC1, out_ready toggling -> bubbles compress; output sequence is exactly 0xC0,0xC1; out_data is stable while stalled.
- Chain holding 2 beats, assert flush for 1 cycle with in_valid=1 -> in_ready=0 and out_valid=0 that cycle; next cycle out_valid=0 and occupancy=0; a subsequent 0xD0 emerges after 3 edges.
- Mid-stream reset=0 with 3 beats in flight -> after release out_valid=0 and out_data=0x0000; no stale beat appears in the following 10 cycles.
